// File: rtl/queue_dispatch_if.sv
// Bundle of the dispatcher's data-path signals.
//
// Parameters:
//   QUEUE_QUANTITY - number of source FIFOs
//   DATA_BITS      - word width per FIFO
//
// Signals (direction as seen by the dispatcher, i.e. the slave modport):
//   enb            in   block enable; low blocks new pops only
//   selector       in   queue index granted by the upstream arbiter
//   sel_valid      in   grant valid
//   buf_empty      in   per-FIFO empty flags
//   fifo_data      in   concatenated FIFO read ports, queue q at [q*DATA_BITS +: DATA_BITS]
//   ready_in       in   downstream ready
//   pop            out  one-hot FIFO read strobes
//   data_out       out  head word of the output buffer
//   qid_out        out  source queue of data_out
//   valid_out      out  data_out/qid_out valid
//   dispatch_count out  per-queue 16-bit dispatched-word counters
//
// The master modport is the environment side (FIFOs, arbiter and downstream sink).

interface queue_dispatch_if #(
    parameter int unsigned QUEUE_QUANTITY = 4,
    parameter int unsigned DATA_BITS      = 8
);
    localparam int unsigned SEL_BITS = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1;

    logic                                enb;
    logic [SEL_BITS-1:0]                 selector;
    logic                                sel_valid;
    logic [QUEUE_QUANTITY-1:0]           buf_empty;
    logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data;
    logic                                ready_in;
    logic [QUEUE_QUANTITY-1:0]           pop;
    logic [DATA_BITS-1:0]                data_out;
    logic [SEL_BITS-1:0]                 qid_out;
    logic                                valid_out;
    logic [QUEUE_QUANTITY*16-1:0]        dispatch_count;

    modport master (
        output enb, selector, sel_valid, buf_empty, fifo_data, ready_in,
        input  pop, data_out, qid_out, valid_out, dispatch_count
    );

    modport slave (
        input  enb, selector, sel_valid, buf_empty, fifo_data, ready_in,
        output pop, data_out, qid_out, valid_out, dispatch_count
    );
endinterface

// File: rtl/queue_dispatch.sv
// Queue dispatcher: pops the FIFO granted by an external round-robin arbiter,
// captures the word one cycle later (FIFO read latency 1) and presents it,
// tagged with its source queue, through a 2-entry output buffer with a
// valid/ready handshake. Sustains one word per cycle when downstream is ready.
//
// Ports:
//   clk  - clock, all logic on the rising edge
//   rst  - synchronous active-high reset
//   bus  - queue_dispatch_if.slave (enb, selector, sel_valid, buf_empty,
//          fifo_data, ready_in in; pop, data_out, qid_out, valid_out,
//          dispatch_count out)
//
// Optional feature: define QUEUE_DISPATCH_COUNTERS_EN to build per-queue
// 16-bit wrapping dispatch counters; otherwise dispatch_count is tied to 0.

module queue_dispatch #(
    parameter int unsigned QUEUE_QUANTITY = 4,
    parameter int unsigned DATA_BITS      = 8
) (
    input logic              clk,
    input logic              rst,
    queue_dispatch_if.slave  bus
);
    localparam int unsigned SEL_BITS = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1;

    typedef logic [SEL_BITS-1:0]  sel_t;
    typedef logic [DATA_BITS-1:0] word_t;

    // ------------------------------------------------------------------
    // Pop request
    // ------------------------------------------------------------------
    logic       sel_in_range;
    logic       rd_en;       // downstream handshake this cycle
    logic       wr_en;       // in-flight word captured this cycle
    logic       pop_ok;
    logic [2:0] level;       // committed slots after this cycle's read

    logic       in_flight_q;
    sel_t       tag_q;
    logic [1:0] occ_q;
    logic [1:0] occ_d;
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    word_t      word_mem_q [2];
    sel_t       tag_mem_q  [2];
    word_t      cap_word;

    assign sel_in_range = 32'(bus.selector) < QUEUE_QUANTITY;
    assign rd_en        = bus.valid_out && bus.ready_in;
    assign wr_en        = in_flight_q;

    // Occupancy plus the word already in flight, minus what leaves now. Keeping
    // this below 2 guarantees the buffer has room when the popped word lands.
    assign level = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, rd_en};

    assign pop_ok = !rst && bus.enb && bus.sel_valid && sel_in_range &&
                    !bus.buf_empty[bus.selector] && (level < 3'd2);

    always_comb begin
        bus.pop = '0;
        if (pop_ok) begin
            bus.pop[bus.selector] = 1'b1;
        end
    end

    // FIFO read data arrives one cycle after the pop, on the tagged slice.
    assign cap_word = bus.fifo_data[tag_q*DATA_BITS +: DATA_BITS];

    // ------------------------------------------------------------------
    // In-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight_q <= 1'b0;
            tag_q       <= '0;
        end else begin
            in_flight_q <= pop_ok;
            if (pop_ok) begin
                tag_q <= bus.selector;
            end
        end
    end

    // ------------------------------------------------------------------
    // 2-entry output buffer of {tag, word}
    // ------------------------------------------------------------------
    always_comb begin
        occ_d = occ_q;
        unique case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q         <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            word_mem_q[0] <= '0;
            word_mem_q[1] <= '0;
            tag_mem_q[0]  <= '0;
            tag_mem_q[1]  <= '0;
        end else begin
            occ_q <= occ_d;
            if (wr_en) begin
                word_mem_q[wr_ptr_q] <= cap_word;
                tag_mem_q[wr_ptr_q]  <= tag_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (rd_en) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // The pop gate makes this unreachable; firing means the gate is broken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(wr_en && !rd_en && occ_q == 2'd2))
                else $error("queue_dispatch: output buffer overflow");
        end
    end

    assign bus.valid_out = (occ_q != 2'd0);
    assign bus.data_out  = word_mem_q[rd_ptr_q];
    assign bus.qid_out   = tag_mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Dispatch counters
    // ------------------------------------------------------------------
`ifdef QUEUE_DISPATCH_COUNTERS_EN
    logic [15:0] cnt_q [QUEUE_QUANTITY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int q = 0; q < int'(QUEUE_QUANTITY); q++) begin
                cnt_q[q] <= 16'd0;
            end
        end else begin
            for (int q = 0; q < int'(QUEUE_QUANTITY); q++) begin
                if (bus.pop[q]) begin
                    cnt_q[q] <= cnt_q[q] + 16'd1;  // wraps FFFF -> 0
                end
            end
        end
    end

    always_comb begin
        bus.dispatch_count = '0;
        for (int q = 0; q < int'(QUEUE_QUANTITY); q++) begin
            bus.dispatch_count[q*16 +: 16] = cnt_q[q];
        end
    end
`else
    assign bus.dispatch_count = '0;
`endif

endmodule

// File: tb/tb_queue_dispatch.sv
// Self-checking bench for queue_dispatch (QUEUE_QUANTITY=4, DATA_BITS=8).
// Single-cycle pop/capture behaviour comes from a vector table; stall, drain,
// reset-abort, enable-drop and counter behaviour from hand-written sequences.

module tb_queue_dispatch;
    localparam int unsigned QQ = 4;
    localparam int unsigned DB = 8;
`ifdef QUEUE_DISPATCH_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [31:0] FDATA = 32'h44A5_2211;

    logic clk;
    logic rst;

    queue_dispatch_if #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB)) bus ();

    queue_dispatch #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus.enb       = 1'b0;
        bus.selector  = 2'd0;
        bus.sel_valid = 1'b0;
        bus.buf_empty = 4'b1111;
        bus.fifo_data = FDATA;
        bus.ready_in  = 1'b0;
    endtask

    // Ends at a falling edge with rst low.
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Queue-0 FIFO model: a pop at cycle N puts the popped word on slice 0
    // before cycle N+1. Words are 30, 31, ... in order.
    logic [7:0] next_word;
    logic [7:0] exp_word;
    int         pops;
    int         drained;
    logic       pend;

    task automatic model_init();
        next_word = 8'h30;
        exp_word  = 8'h30;
        pops      = 0;
        drained   = 0;
        pend      = 1'b0;
    endtask

    // Called at a falling edge after inputs are set; returns at the next one.
    task automatic tick();
        #1;
        if (bus.pop[0]) begin
            pops++;
            pend = 1'b1;
        end
        if (bus.valid_out && bus.ready_in) begin
            check("drain_data", {56'd0, bus.data_out}, {56'd0, exp_word});
            check("drain_qid", {62'd0, bus.qid_out}, 64'd0);
            exp_word = exp_word + 8'd1;
            drained++;
        end
        @(negedge clk);
        if (pend) begin
            bus.fifo_data[7:0] = next_word;
            next_word          = next_word + 8'd1;
            pend               = 1'b0;
        end
    endtask

    typedef struct {
        logic       enb;
        logic [1:0] sel;
        logic       sv;
        logic [3:0] empty;
        logic [3:0] exp_pop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [1:0] exp_qid;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         npops;
        logic [63:0] exp_cnt;

        rst = 1'b1;
        idle_inputs();

        // enb sel sv empty | pop valid data qid
        vecs[0] = '{1'b1, 2'd2, 1'b1, 4'b0000, 4'b0100, 1'b1, 8'hA5, 2'd2};
        vecs[1] = '{1'b1, 2'd0, 1'b1, 4'b0000, 4'b0001, 1'b1, 8'h11, 2'd0};
        vecs[2] = '{1'b1, 2'd3, 1'b1, 4'b0000, 4'b1000, 1'b1, 8'h44, 2'd3};
        vecs[3] = '{1'b1, 2'd1, 1'b1, 4'b0010, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[4] = '{1'b0, 2'd1, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[5] = '{1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[6] = '{1'b1, 2'd1, 1'b1, 4'b1101, 4'b0010, 1'b1, 8'h22, 2'd1};
        vecs[7] = '{1'b1, 2'd3, 1'b1, 4'b1111, 4'b0000, 1'b0, 8'h00, 2'd0};

        // Reset state, including pop held low while rst is asserted.
        repeat (2) @(negedge clk);
        bus.enb       = 1'b1;
        bus.sel_valid = 1'b1;
        bus.buf_empty = 4'b0000;
        #1;
        check("rst_pop", {60'd0, bus.pop}, 64'd0);
        check("rst_valid", {63'd0, bus.valid_out}, 64'd0);
        check("rst_data", {56'd0, bus.data_out}, 64'd0);
        check("rst_qid", {62'd0, bus.qid_out}, 64'd0);
        check("rst_count", bus.dispatch_count, 64'd0);

        // Table: single pop, then capture one cycle later.
        for (int i = 0; i < 8; i++) begin
            reset_dut();
            bus.enb       = vecs[i].enb;
            bus.selector  = vecs[i].sel;
            bus.sel_valid = vecs[i].sv;
            bus.buf_empty = vecs[i].empty;
            #1;
            check($sformatf("vec%0d_pop", i), {60'd0, bus.pop}, {60'd0, vecs[i].exp_pop});
            @(negedge clk);
            bus.sel_valid = 1'b0;
            #1;
            check($sformatf("vec%0d_pop_off", i), {60'd0, bus.pop}, 64'd0);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), {63'd0, bus.valid_out},
                  {63'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_data", i), {56'd0, bus.data_out},
                  {56'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_qid", i), {62'd0, bus.qid_out}, {62'd0, vecs[i].exp_qid});
        end

        // All FIFOs empty with grants: nothing for 20 cycles.
        reset_dut();
        bus.enb       = 1'b1;
        bus.sel_valid = 1'b1;
        bus.ready_in  = 1'b1;
        bus.buf_empty = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            bus.selector = 2'(c % 4);
            #1;
            check("empty_pop", {60'd0, bus.pop}, 64'd0);
            check("empty_valid", {63'd0, bus.valid_out}, 64'd0);
            @(negedge clk);
        end

        // Backpressure: two pops fill the buffer, then drain at full rate.
        reset_dut();
        model_init();
        bus.enb       = 1'b1;
        bus.selector  = 2'd0;
        bus.sel_valid = 1'b1;
        bus.buf_empty = 4'b0000;
        repeat (10) tick();
        check("stall_pops", 64'(pops), 64'd2);
        #1;
        check("stall_pop_now", {60'd0, bus.pop}, 64'd0);
        check("stall_valid", {63'd0, bus.valid_out}, 64'd1);
        check("stall_head", {56'd0, bus.data_out}, 64'h30);
        @(negedge clk);
        bus.ready_in = 1'b1;
        repeat (10) tick();
        check("drain_pops", 64'(pops), 64'd12);
        check("drain_count", 64'(drained), 64'd10);
        check("drain_dispatch", bus.dispatch_count, CNT_EN ? 64'd12 : 64'd0);

        // Reset the cycle after a pop: that word never appears.
        reset_dut();
        bus.enb       = 1'b1;
        bus.selector  = 2'd2;
        bus.sel_valid = 1'b1;
        bus.buf_empty = 4'b0000;
        bus.ready_in  = 1'b1;
        #1;
        check("abort_pop", {60'd0, bus.pop}, 64'h4);
        @(negedge clk);
        rst           = 1'b1;
        bus.sel_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("abort_valid", {63'd0, bus.valid_out}, 64'd0);
            @(negedge clk);
        end

        // Enable dropped with occ=1 and one word in flight.
        reset_dut();
        model_init();
        bus.enb       = 1'b1;
        bus.selector  = 2'd0;
        bus.sel_valid = 1'b1;
        bus.buf_empty = 4'b0000;
        repeat (2) tick();
        bus.enb = 1'b0;
        repeat (2) tick();
        check("enb_pops", 64'(pops), 64'd2);
        #1;
        check("enb_valid", {63'd0, bus.valid_out}, 64'd1);
        check("enb_head", {56'd0, bus.data_out}, 64'h30);
        @(negedge clk);
        bus.ready_in = 1'b1;
        repeat (4) tick();
        check("enb_drained", 64'(drained), 64'd2);
        check("enb_pops_after", 64'(pops), 64'd2);
        #1;
        check("enb_valid_end", {63'd0, bus.valid_out}, 64'd0);
        @(negedge clk);

        // Counters: wrap on queue 1 when enabled, stay zero otherwise.
        npops   = CNT_EN ? 65537 : 300;
        exp_cnt = CNT_EN ? 64'h0000_0000_0001_0000 : 64'd0;
        reset_dut();
        bus.enb       = 1'b1;
        bus.selector  = 2'd1;
        bus.sel_valid = 1'b1;
        bus.buf_empty = 4'b0000;
        bus.ready_in  = 1'b1;
        n = 0;
        for (int c = 0; c < 70000 && n < npops; c++) begin
            #1;
            if (bus.pop[1]) n++;
            @(negedge clk);
            if (n == npops) bus.sel_valid = 1'b0;
        end
        check("cnt_pops", 64'(n), 64'(npops));
        repeat (3) @(negedge clk);
        #1;
        check("cnt_value", bus.dispatch_count, exp_cnt);
        check("cnt_idle_valid", {63'd0, bus.valid_out}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/queue_dispatch.md
QUEUE_DISPATCH -- requirements
Module: queue_dispatch

Interface
REQ-001 Parameter QUEUE_QUANTITY, default 4, number of source FIFOs.
REQ-002 Parameter DATA_BITS, default 8, word width per FIFO.
REQ-003 clk  input  1  clock; all logic on posedge clk.
REQ-004 rst  input  1  reset rst, synchronous, active-high.
REQ-005 enb  input  1  block enable; low blocks new pops only.
REQ-006 selector  input  $clog2(QUEUE_QUANTITY)  queue index granted by the round-robin arbiter.
REQ-007 sel_valid  input  1  grant valid (arbiter out_enb).
REQ-008 buf_empty  input  QUEUE_QUANTITY  per-FIFO empty flags.
REQ-009 fifo_data  input  QUEUE_QUANTITY*DATA_BITS  FIFO read ports; queue q occupies bits [q*DATA_BITS +: DATA_BITS].
REQ-010 pop  output  QUEUE_QUANTITY  one-hot FIFO read strobes.
REQ-011 data_out  output  DATA_BITS  head word of output buffer.
REQ-012 qid_out  output  $clog2(QUEUE_QUANTITY)  source queue of data_out.
REQ-013 valid_out  output  1  data_out/qid_out valid.
REQ-014 ready_in  input  1  downstream accepts when valid_out && ready_in.
REQ-015 dispatch_count  output  QUEUE_QUANTITY*16  per-queue dispatched-word counters (see Configuration).

Function
REQ-016 FIFO read latency SHALL be 1: word for pop[q] at cycle N is captured from fifo_data slice q at cycle N+1.
REQ-017 pop[selector] SHALL assert (combinationally, one cycle) iff enb && sel_valid && selector<QUEUE_QUANTITY && !buf_empty[selector] && (occ + in_flight - (valid_out && ready_in)) < 2.
REQ-018 At most one pop bit SHALL be high per cycle; all zero otherwise.
REQ-019 in_flight register SHALL set on the cycle after a pop and hold the popped queue index as tag; it clears when no pop occurred in the prior cycle.
REQ-020 Output buffer SHALL be a 2-entry FIFO (occ 0..2) of {tag, word}; capture writes tail, valid_out && ready_in reads head; simultaneous write and read at occ=1 or 2 keep occ unchanged.
REQ-021 valid_out SHALL equal (occ != 0); data_out/qid_out SHALL present the head entry and hold stable while valid_out && !ready_in.
REQ-022 Sustained throughput SHALL be 1 word/cycle when ready_in stays high and grants are continuous.
REQ-023 Occupancy SHALL never exceed 2; any overflow condition is a design error.
REQ-024 enb low SHALL block new pops only; in-flight capture and output drain continue.
REQ-025 selector out of range, sel_valid low or buf_empty[selector] high SHALL suppress pop with no state change.

Reset
REQ-026 On rst: pop=0, valid_out=0, data_out=0, qid_out=0, occ=0, in_flight=0, dispatch_count=0.
REQ-027 rst asserted while a pop is in flight SHALL discard that word; the cycle after rst deasserts, no stale capture occurs.

Configuration
REQ-028 Macro QUEUE_DISPATCH_COUNTERS_EN defined: dispatch_count slice q (16 bits) SHALL increment on each pop[q], wrapping 16'hFFFF -> 0.
REQ-029 Macro undefined: dispatch_count port SHALL remain present and tied to 0; no counter registers are synthesized.

Verification
REQ-030 QUEUE_QUANTITY=4; queue 2 non-empty holding 8'hA5, selector=2, sel_valid=1, ready_in=1 -> pop=4'b0100 for one cycle; next cycle valid_out=1, data_out=8'hA5, qid_out=2.
REQ-031 ready_in=0, continuous grants on queue 0 -> exactly 2 pops, occ=2, pop stays 0; raise ready_in -> words drain in order, pops resume at 1/cycle.
REQ-032 buf_empty=4'b1111 with sel_valid=1 -> pop=0, valid_out=0 for 20 cycles.
REQ-033 rst pulsed the cycle after a pop -> valid_out=0 after rst; no word emitted for that pop.
REQ-034 With QUEUE_DISPATCH_COUNTERS_EN, 65537 pops on queue 1 -> dispatch_count[31:16]=1, other slices 0; without macro dispatch_count=0 throughout.
REQ-035 enb dropped while occ=1 and in_flight=1 -> no new pop, occ reaches 2, both words drain in order.
